// File: rtl/conv_window_sequencer_pkg.sv
// Shared FSM encoding and 3x3 tap indices for the convolution window sequencer.
package conv_window_sequencer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Bit positions of each tap inside en_read, MSB is top-left.
  localparam int TAP_TL = 8;
  localparam int TAP_T  = 7;
  localparam int TAP_TR = 6;
  localparam int TAP_L  = 5;
  localparam int TAP_C  = 4;
  localparam int TAP_R  = 3;
  localparam int TAP_BL = 2;
  localparam int TAP_B  = 1;
  localparam int TAP_BR = 0;

endpackage

// File: rtl/conv_window_sequencer_pad_mask_gen.sv
// Zero-padding mask for a 3x3 window centred at (r,c); taps outside the map are cleared.
module pad_mask_gen
  import conv_window_sequencer_pkg::*;
#(
  parameter int width    = 80,
  parameter int height   = 8,
  parameter int width_b  = 7,
  parameter int height_b = 3
) (
  input  logic [height_b-1:0] r,
  input  logic [width_b-1:0]  c,
  output logic [8:0]          mask
);

  localparam logic [width_b-1:0]  C_LAST = width_b'(width - 1);
  localparam logic [height_b-1:0] R_LAST = height_b'(height - 1);

  logic up, down, left, right;

  assign up    = (r != '0);
  assign down  = (r != R_LAST);
  assign left  = (c != '0);
  assign right = (c != C_LAST);

  assign mask[TAP_TL] = up & left;
  assign mask[TAP_T]  = up;
  assign mask[TAP_TR] = up & right;
  assign mask[TAP_L]  = left;
  assign mask[TAP_C]  = 1'b1;
  assign mask[TAP_R]  = right;
  assign mask[TAP_BL] = down & left;
  assign mask[TAP_B]  = down;
  assign mask[TAP_BR] = down & right;

endmodule

// File: rtl/conv_window_sequencer.sv
// Raster-scans a feature map, issuing one registered 3x3 window descriptor per cycle.
module conv_window_sequencer
  import conv_window_sequencer_pkg::*;
#(
  parameter int width    = 80,
  parameter int height   = 8,
  parameter int width_b  = 7,
  parameter int height_b = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                bias_on,
  input  logic                stall,
  output logic [height_b-1:0] row_addr,
  output logic [width_b-1:0]  col_addr,
  output logic [8:0]          en_read,
  output logic                en_bias,
  output logic                valid,
  output logic                busy,
  output logic                done
);

  localparam logic [width_b-1:0]  C_LAST = width_b'(width - 1);
  localparam logic [height_b-1:0] R_LAST = height_b'(height - 1);

  logic [1:0]          state;
  logic                bias_q;
  logic [height_b-1:0] r_nxt;
  logic [width_b-1:0]  c_nxt;
  logic [8:0]          mask_nxt;
  logic                last;

  // The output registers double as the scan counters while in RUN.
  assign last = (row_addr == R_LAST) && (col_addr == C_LAST);
  assign busy = (state != ST_IDLE);

  always_comb begin
    r_nxt = '0;
    c_nxt = '0;
    if (state == ST_RUN && !last) begin
      if (col_addr == C_LAST) begin
        r_nxt = row_addr + 1'b1;
      end else begin
        r_nxt = row_addr;
        c_nxt = col_addr + 1'b1;
      end
    end
  end

  pad_mask_gen #(
    .width(width), .height(height), .width_b(width_b), .height_b(height_b)
  ) u_mask (
    .r    (r_nxt),
    .c    (c_nxt),
    .mask (mask_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      bias_q   <= 1'b0;
      row_addr <= '0;
      col_addr <= '0;
      en_read  <= '0;
      en_bias  <= 1'b0;
      valid    <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RUN;
            bias_q   <= bias_on;
            row_addr <= r_nxt;
            col_addr <= c_nxt;
            en_read  <= mask_nxt;
            en_bias  <= bias_on;
            valid    <= 1'b1;
          end
        end
        ST_RUN: begin
          // Stall freezes every output; the last window also waits here.
          if (!stall) begin
            if (last) begin
              state    <= ST_DRAIN;
              row_addr <= '0;
              col_addr <= '0;
              en_read  <= '0;
              en_bias  <= 1'b0;
              valid    <= 1'b0;
            end else begin
              row_addr <= r_nxt;
              col_addr <= c_nxt;
              en_read  <= mask_nxt;
              en_bias  <= bias_q;
            end
          end
        end
        ST_DRAIN: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer: full frames, stall, ignored start, mid-frame reset.
module tb_conv_window_sequencer;

  localparam int W = 80;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       bias_on = 1'b0;
  logic       stall = 1'b0;
  logic [2:0] row_addr;
  logic [6:0] col_addr;
  logic [8:0] en_read;
  logic       en_bias, valid, busy, done;

  int n_assert = 0;
  int n_fail   = 0;

  conv_window_sequencer #(.width(W), .height(H), .width_b(7), .height_b(3)) dut (
    .clk(clk), .rst(rst), .start(start), .bias_on(bias_on), .stall(stall),
    .row_addr(row_addr), .col_addr(col_addr), .en_read(en_read),
    .en_bias(en_bias), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] model_mask(int r, int c);
    logic [8:0] m;
    m = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
          m[8 - ((dr + 1) * 3 + (dc + 1))] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] obs_win();
    return 32'({valid, busy, done, row_addr, col_addr, en_read, en_bias});
  endfunction

  function automatic logic [31:0] exp_win(int r, int c, logic b);
    logic [2:0] rr;
    logic [6:0] cc;
    rr = 3'(r);
    cc = 7'(c);
    return 32'({1'b1, 1'b1, 1'b0, rr, cc, model_mask(r, c), b});
  endfunction

  // Walks a frame whose first window is already on the outputs.
  task automatic scan(input logic b, input int stall_r, input int stall_c, input int stall_n,
                      input int bs_r, input int bs_c, input int rst_r, input int rst_c,
                      input int exp_valid);
    int er, ec, vcount;
    er = 0; ec = 0; vcount = 0;
    for (int k = 0; k < W * H; k++) begin
      check("window", obs_win(), exp_win(er, ec, b));
      vcount++;
      if (er == 0 && ec == 0)   check("mask_0_0",  32'(en_read), 32'(9'b000_011_011));
      if (er == 7 && ec == 79)  check("mask_7_79", 32'(en_read), 32'(9'b110_110_000));
      if (er == 3 && ec == 40)  check("mask_3_40", 32'(en_read), 32'(9'h1FF));
      if (er == 0 && ec == 40)  check("mask_0_40", 32'(en_read), 32'(9'b000_111_111));
      if (er == 4 && ec == 79)  check("mask_4_79", 32'(en_read), 32'(9'b110_110_110));
      if (er == stall_r && ec == stall_c) begin
        stall = 1'b1;
        for (int s = 0; s < stall_n; s++) begin
          step();
          check("stall_hold", obs_win(), exp_win(er, ec, b));
          vcount++;
        end
        stall = 1'b0;
      end
      if (er == bs_r && ec == bs_c) begin
        start = 1'b1;
        bias_on = ~b;
      end
      if (er == rst_r && ec == rst_c) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_valid", 32'(valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_en_read", 32'(en_read), 32'(0));
        return;
      end
      if (er == H - 1 && ec == W - 1) begin
        step();
        check("drain", obs_win(), 32'({1'b0, 1'b1, 1'b0, 20'd0}));
        step();
        check("done_pulse", obs_win(), 32'({1'b0, 1'b1, 1'b1, 20'd0}));
        step();
        check("idle", obs_win(), 32'(0));
        check("valid_count", 32'(vcount), 32'(exp_valid));
        return;
      end
      if (ec == W - 1) begin
        ec = 0;
        er++;
      end else begin
        ec++;
      end
      step();
      start = 1'b0;
    end
  endtask

  initial begin
    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1; bias_on = 1'b1;
    step(); step();
    check("reset_state", obs_win(), 32'(0));
    // Start in the first cycle after reset release.
    rst = 1'b0;
    step();
    start = 1'b0;
    scan(1'b1, -1, -1, 0, -1, -1, -1, -1, 640);

    // Bias off, stall at (2,10), ignored start at (1,5).
    start = 1'b1; bias_on = 1'b0;
    step();
    start = 1'b0;
    scan(1'b0, 2, 10, 5, 1, 5, -1, -1, 645);

    // Reset mid-frame, then restart from (0,0).
    start = 1'b1; bias_on = 1'b1;
    step();
    start = 1'b0;
    scan(1'b1, -1, -1, 0, -1, -1, 5, 30, 0);
    check("rst_idle_hold", obs_win(), 32'(0));
    start = 1'b1; bias_on = 1'b1;
    step();
    start = 1'b0;
    scan(1'b1, -1, -1, 0, -1, -1, -1, -1, 640);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_sequencer.md
CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

Interface
REQ-001 SHALL have parameter width, default 80, meaning feature-map columns.
REQ-002 SHALL have parameter height, default 8, meaning feature-map rows.
REQ-003 SHALL have parameter width_b, default 7, meaning column-address bits.
REQ-004 SHALL have parameter height_b, default 3, meaning row-address bits.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge clk.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: one-cycle request to scan one frame.
REQ-008 SHALL have port bias_on, input, 1 bit: frame adds bias; sampled when start is accepted.
REQ-009 SHALL have port stall, input, 1 bit: downstream not ready; freeze the scan.
REQ-010 SHALL have port row_addr, output, height_b bits: window centre row.
REQ-011 SHALL have port col_addr, output, width_b bits: window centre column.
REQ-012 SHALL have port en_read, output, 9 bits: zero-padding mask to the control part.
REQ-013 SHALL have port en_bias, output, 1 bit: bias enable to the control part.
REQ-014 SHALL have port valid, output, 1 bit: row_addr, col_addr, en_read and en_bias describe a live window.
REQ-015 SHALL have port busy, output, 1 bit: frame in progress.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse at end of frame.

Function
REQ-017 SHALL run an FSM with states IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE->RUN SHALL occur on start=1; the block SHALL latch bias_on and set (r,c)=(0,0).
REQ-019 In RUN with stall=0, the block SHALL issue one window per cycle, registered, with valid=1 in the cycle after acceptance, in raster order: c increments; at c=width-1, c=0 and r increments.
REQ-020 In RUN with stall=1, all outputs and counters SHALL hold and valid SHALL stay 1.
REQ-021 After issuing (height-1,width-1), RUN->DRAIN SHALL occur; DRAIN SHALL last exactly 1 cycle with valid=0, covering the control part's 1-cycle en_read/en_bias register.
REQ-022 DRAIN->DONE SHALL occur; DONE SHALL assert done=1 for 1 cycle, then the FSM SHALL return to IDLE.
REQ-023 busy SHALL be 1 in RUN, DRAIN and DONE; start SHALL be ignored while busy=1.
REQ-024 en_read bit mapping, MSB to LSB, SHALL be: bit8 (r-1,c-1), bit7 (r-1,c), bit6 (r-1,c+1), bit5 (r,c-1), bit4 (r,c), bit3 (r,c+1), bit2 (r+1,c-1), bit1 (r+1,c), bit0 (r+1,c+1).
REQ-025 An en_read bit SHALL be 1 only if its tap lies inside 0..height-1 by 0..width-1; r=0 SHALL clear bits 8..6, r=height-1 SHALL clear bits 2..0, c=0 SHALL clear bits 8,5,2, and c=width-1 SHALL clear bits 6,3,0.
REQ-026 en_bias SHALL equal the latched bias_on whenever valid=1, and SHALL be 0 otherwise.
REQ-027 When valid=0, en_read, row_addr and col_addr SHALL be 0.
REQ-028 Counters SHALL compare against width-1 and height-1 and SHALL never wrap through unused codes; width_b and height_b SHALL be wide enough for width-1 and height-1.
REQ-029 If stall=1 in the cycle of the last window, the RUN->DRAIN transition SHALL wait until stall=0.

Reset
REQ-030 rst=1 SHALL force IDLE, r=c=0, latched bias=0 and all outputs to 0 on the next clk edge, including mid-frame; rst SHALL take priority over start.
REQ-031 After rst deasserts, the block SHALL accept start in the first cycle.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding and the tap-index constants (TAP_TL=8 ... TAP_BR=0).
REQ-033 The padding-mask generation SHALL be one combinational sub-module, pad_mask_gen (inputs r,c; output mask), instantiated once.

Verification
REQ-034 Reset, then start with bias_on=1, width=80, height=8 -> 640 valid cycles; the first window (0,0) shows en_read=9'b000_011_011 and en_bias=1; the last window (7,79) shows en_read=9'b110_110_000; done pulses 2 cycles after the last valid.
REQ-035 Interior window (3,40) -> en_read=9'h1FF; window (0,40) -> 9'b000_111_111; window (4,79) -> 9'b110_110_110.
REQ-036 Assert stall for 5 cycles at window (2,10) -> outputs are frozen at (2,10) for 5 cycles, the next window is (2,11), and the total frame length is 640+5 valid cycles.
REQ-037 Start asserted while busy at window (1,5) -> ignored, with the scan sequence unchanged; a start with bias_on=0 after done -> en_bias=0 throughout.
REQ-038 rst asserted at window (5,30) -> next cycle valid=0, busy=0 and en_read=0; a following start restarts at (0,0).
